mem_arbiter: RTL
================

# mem_arbiter

Shares the single backing memory port between the instruction fetcher and the data-memory access path of the multi-cycle core. Each requester issues one-cycle order pulses and receives a one-cycle done pulse, matching the core's fetch/execute wait-state handshake. The block latches requests and grants the memory round-robin on ties. It drives one registered req/ack transaction at a time.

## Interface
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data/instruction word width

- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- f_order  in  1  fetch request pulse (one cycle)
- f_addr  in  ADDR_W  fetch address, sampled with f_order
- f_inst  out  DATA_W  fetched word, valid while f_done=1 and held afterwards
- f_done  out  1  fetch completion pulse (one cycle)
- d_order  in  1  data request pulse (one cycle)
- d_we  in  1  1=write, 0=read, sampled with d_order
- d_addr  in  ADDR_W  data address, sampled with d_order
- d_wdata  in  DATA_W  write data, sampled with d_order
- d_rdata  out  DATA_W  read data, valid while d_done=1 and held afterwards
- d_done  out  1  data completion pulse (one cycle)
- m_req  out  1  memory request, level, held until m_ack
- m_we  out  1  memory write enable, stable while m_req=1
- m_addr  out  ADDR_W  memory address, stable while m_req=1
- m_wdata  out  DATA_W  memory write data, stable while m_req=1
- m_rdata  in  DATA_W  memory read data, valid in the m_ack cycle
- m_ack  in  1  memory completion pulse (one cycle)
- err  out  1  sticky: an order was dropped because its side already had a pending request

## Operation
- Per side: one pending slot (flag and latched addr/we/wdata). An order pulse with the slot empty sets pending and latches the fields. An order with the slot full is dropped, the slot is unchanged, and err sets.
- FSM states: IDLE, BUSY_F, BUSY_D.
- IDLE, only f pending: grant f, go to BUSY_F. Only d pending: grant d, go to BUSY_D. Both pending: grant the side not in last_grant. last_grant resets to D, so fetch wins the first tie.
- Grant actions: clear that side's pending; load m_addr/m_we/m_wdata from the slot (m_we=0, m_wdata=0 for fetch); set m_req=1; update last_grant.
- BUSY_x with m_ack=1: clear m_req, return to IDLE, pulse x_done.
  - On a fetch or data read, register m_rdata into f_inst or d_rdata.
  - On a data write, d_rdata is unchanged.
- An order for a side arriving while that side is BUSY fills its empty pending slot, so each side has one-deep queueing.
- m_ack in IDLE is ignored.
- Reset values: m_req=0, m_we=0, m_addr=0, m_wdata=0, f_done=0, d_done=0, f_inst=0, d_rdata=0, err=0. Pending flags clear, state=IDLE, last_grant=D.
- Reset mid-transaction: everything returns to reset values immediately. No done pulse is produced, and a subsequent stray m_ack is ignored.

## Timing
- All outputs are registered.
- Order sampled at edge k: pending is set after k. Grant happens at edge k+1, so m_req=1 from k+1.
- m_ack sampled at edge j (j>=k+2): m_req=0 and x_done=1 for the cycle after j, with data valid in the same cycle.
- Minimum order-to-done: 3 cycles.
- Back-to-back: the next grant happens at the edge after the done edge, giving one idle cycle with m_req=0 between transactions.
- x_done is exactly one cycle wide. The bus fields hold their last value after the transaction.
- An order arriving on the same edge a grant clears that side's pending is not lost, because the slot is refilled.

## Test plan
- Fetch read
  - Stimulus: f_order with f_addr=0x10; memory acks 2 cycles after m_req with m_rdata=0xDEADBEEF.
  - Response: m_addr=0x10, m_we=0; f_done pulses once with f_inst=0xDEADBEEF; order-to-done is 4 cycles.
- Data write
  - Stimulus: d_order, d_we=1, d_addr=0x20, d_wdata=0x1234.
  - Response: m_we=1, m_wdata=0x1234; d_done pulses once; d_rdata stays 0.
- Simultaneous orders
  - Stimulus: f_order and d_order in the same cycle, right after reset.
  - Response: fetch is served first, then data. The second tie afterwards grants fetch again, since last_grant is now D.
- Queueing and overflow
  - Stimulus: a d_order during BUSY_D is accepted and served next. A third d_order before that grant is dropped.
  - Response: the dropped order sets err=1 and err stays 1.
- Reset mid-operation
  - Stimulus: rstn=0 while in BUSY_F with m_req=1; m_ack then arrives after reset.
  - Response: m_req=0 the next cycle, no f_done pulse, and the stray m_ack is ignored.
- Stall hold
  - Stimulus: memory withholds m_ack for 20 cycles.
  - Response: m_req, m_addr, m_we and m_wdata are constant for the whole wait, and no done pulse occurs.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one backing memory port between the instruction fetcher (f_*)
//   and the data-memory access path (d_*) of the multi-cycle core.
//
//   Each side owns a one-deep pending slot that captures an order pulse. The
//   FSM serves one memory transaction at a time. When both sides are pending
//   it picks the side that was not granted last.
//
//   Ports:
//     clk, rstn                      clock, synchronous active-low reset
//     f_order, f_addr                fetch order pulse and address
//     f_inst, f_done                 fetched word (held) and completion pulse
//     d_order, d_we, d_addr, d_wdata data order pulse and its fields
//     d_rdata, d_done                read data (held) and completion pulse
//     m_req, m_we, m_addr, m_wdata   memory request (level) and its fields
//     m_rdata, m_ack                 memory read data and completion pulse
//     err                            sticky: an order was dropped on a full slot
//
//   Handshakes: an x_order is a single-cycle pulse, and its fields are
//   sampled in the same cycle. x_done is a single-cycle pulse, and its data
//   output is valid in that cycle and held afterwards. m_req is a level that
//   stays high until the memory answers with a one-cycle m_ack pulse. While
//   m_req=1, m_we, m_addr and m_wdata do not change. Any m_ack that arrives
//   while no request is outstanding is ignored.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              f_order,
  input  logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f_inst,
  output logic              f_done,
  input  logic              d_order,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Pending slots
  logic              pend_f, pend_d;
  logic [ADDR_W-1:0] slot_f_addr, slot_d_addr;
  logic              slot_d_we;
  logic [DATA_W-1:0] slot_d_wdata;

  // 1 = data side was granted most recently (reset value, so fetch wins the first tie)
  logic last_grant_d;

  logic grant_f, grant_d;

  // Next-state / grant decode
  always_comb begin
    state_nxt = state;
    grant_f   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (pend_f && (!pend_d || last_grant_d)) begin
          grant_f   = 1'b1;
          state_nxt = BUSY_F;
        end else if (pend_d) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end
      end
      BUSY_F, BUSY_D: begin
        if (m_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Datapath, slots and registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend_f       <= 1'b0;
      pend_d       <= 1'b0;
      slot_f_addr  <= '0;
      slot_d_addr  <= '0;
      slot_d_we    <= 1'b0;
      slot_d_wdata <= '0;
      last_grant_d <= 1'b1;
      m_req        <= 1'b0;
      m_we         <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
      f_done       <= 1'b0;
      d_done       <= 1'b0;
      f_inst       <= '0;
      d_rdata      <= '0;
      err          <= 1'b0;
    end else begin
      f_done <= 1'b0;
      d_done <= 1'b0;

      if (grant_f) begin
        m_req        <= 1'b1;
        m_we         <= 1'b0;
        m_addr       <= slot_f_addr;
        m_wdata      <= '0;
        last_grant_d <= 1'b0;
      end
      if (grant_d) begin
        m_req        <= 1'b1;
        m_we         <= slot_d_we;
        m_addr       <= slot_d_addr;
        m_wdata      <= slot_d_wdata;
        last_grant_d <= 1'b1;
      end

      if (state == BUSY_F && m_ack) begin
        m_req  <= 1'b0;
        f_done <= 1'b1;
        f_inst <= m_rdata;
      end
      if (state == BUSY_D && m_ack) begin
        m_req  <= 1'b0;
        d_done <= 1'b1;
        // m_we still holds the granted slot's direction here
        if (!m_we) d_rdata <= m_rdata;
      end

      // A slot being granted on this edge counts as free, so an order that
      // lands on the grant edge refills it instead of being dropped.
      if (f_order && (!pend_f || grant_f)) begin
        pend_f      <= 1'b1;
        slot_f_addr <= f_addr;
      end else if (grant_f) begin
        pend_f <= 1'b0;
      end

      if (d_order && (!pend_d || grant_d)) begin
        pend_d       <= 1'b1;
        slot_d_addr  <= d_addr;
        slot_d_we    <= d_we;
        slot_d_wdata <= d_wdata;
      end else if (grant_d) begin
        pend_d <= 1'b0;
      end

      if ((f_order && pend_f && !grant_f) || (d_order && pend_d && !grant_d))
        err <= 1'b1;
    end
  end

endmodule
